// File: rtl/interlaken_lane_descrambler.sv
// Interlaken 64b/67b receive-lane descrambler.
// Hunts for the metaframe sync word, verifies a run of correctly spaced sync
// words, then locks and descrambles payload with the self-synchronising
// x^58+x^39+1 polynomial. Valid gaps freeze all state; errors are reported as
// single-cycle pulses plus saturating event counters.
module interlaken_lane_descrambler #(
  parameter int          META_FRAME_LEN   = 2048,
  parameter logic [63:0] SYNC_WORD        = 64'h78f678f678f678f6,
  parameter int          SYNC_LOCK_CNT    = 4,
  parameter int          SYNC_LOSS_CNT    = 4,
  parameter int          SCR_MISMATCH_CNT = 3,
  parameter int          CNT_WIDTH        = 16
) (
  input  logic                 USER_CLK,
  input  logic                 SYSTEM_RESET,
  input  logic                 DATA_VALID,
  input  logic                 PASSTHROUGH,
  input  logic [1:0]           HEADER_IN,
  input  logic [63:0]          DATA_IN,
  output logic [63:0]          DATA_OUT,
  output logic [1:0]           HEADER_OUT,
  output logic                 DATA_VALID_OUT,
  output logic                 LOCKED,
  output logic                 SYNC_ERR,
  output logic                 SCR_STATE_ERR,
  output logic [CNT_WIDTH-1:0] LOCK_LOSS_CNT,
  output logic [CNT_WIDTH-1:0] SCR_ERR_CNT
);

  localparam int               POS_W    = $clog2(META_FRAME_LEN);
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(META_FRAME_LEN - 1);
  localparam logic [POS_W-1:0] POS_SYNC = POS_W'(0);
  localparam logic [POS_W-1:0] POS_SSW  = POS_W'(1);
  localparam logic [3:0]       LOCK_TH  = 4'(SYNC_LOCK_CNT);
  localparam logic [3:0]       LOSS_TH  = 4'(SYNC_LOSS_CNT);
  localparam logic [3:0]       MM_TH    = 4'(SCR_MISMATCH_CNT);
  localparam logic [5:0]       SSW_TAG  = 6'b001010;
  localparam logic [1:0]       HDR_CTRL = 2'b10;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  // Statistics counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_WIDTH-1:0] sat_inc_cnt(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  endfunction

  // Small run-length counters stick at 15.
  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (&v) ? v : v + 4'd1;
  endfunction

  // Bit-serial self-synchronising descrambler, bit 0 first; the received
  // (scrambled) bit is what shifts into the state. Returns {state, data}.
  function automatic logic [121:0] descramble(input logic [63:0] din,
                                              input logic [57:0] s_in);
    logic [57:0] s;
    logic [63:0] d;
    s = s_in;
    d = '0;
    for (int i = 0; i < 64; i++) begin
      d[i] = din[i] ^ s[38] ^ s[57];
      s    = {s[56:0], din[i]};
    end
    return {s, d};
  endfunction

  state_t                 state_q, state_d;
  logic [POS_W-1:0]       pos_q, pos_d;
  logic [3:0]             good_q, good_d;
  logic [3:0]             bad_q, bad_d;
  logic [3:0]             mm_q, mm_d;
  logic [57:0]            scr_q, scr_d;
  logic [CNT_WIDTH-1:0]   lock_loss_q, lock_loss_d;
  logic [CNT_WIDTH-1:0]   scr_cnt_q, scr_cnt_d;
  logic [63:0]            dout_q, dout_d;
  logic [1:0]             hdr_q, hdr_d;
  logic                   dvo_q, dvo_d;
  logic                   sync_err_q, sync_err_d;
  logic                   scr_err_q, scr_err_d;

  logic                   is_sync;
  logic                   is_ssw;
  logic                   ssw_match;
  logic [POS_W-1:0]       pos_nxt;
  logic [3:0]             bad_inc;
  logic [3:0]             mm_inc;
  logic [57:0]            descr_s;
  logic [63:0]            descr_data;

  assign is_sync   = (HEADER_IN == HDR_CTRL) && (DATA_IN == SYNC_WORD);
  assign is_ssw    = (HEADER_IN == HDR_CTRL) && (DATA_IN[63:58] == SSW_TAG);
  assign ssw_match = is_ssw && (DATA_IN[57:0] == scr_q);
  assign pos_nxt   = (pos_q == POS_LAST) ? POS_SYNC : pos_q + POS_W'(1);
  assign bad_inc   = sat_inc4(bad_q);
  assign mm_inc    = sat_inc4(mm_q);
  assign {descr_s, descr_data} = descramble(DATA_IN, scr_q);

  // Lock FSM next state, metaframe tracking, descrambling and error events.
  always_comb begin
    state_d     = state_q;
    pos_d       = pos_q;
    good_d      = good_q;
    bad_d       = bad_q;
    mm_d        = mm_q;
    scr_d       = scr_q;
    lock_loss_d = lock_loss_q;
    scr_cnt_d   = scr_cnt_q;
    dout_d      = DATA_IN;
    hdr_d       = HEADER_IN;
    dvo_d       = DATA_VALID;
    sync_err_d  = 1'b0;
    scr_err_d   = 1'b0;

    if (PASSTHROUGH) begin
      // Bypass overrides everything, valid or not, and always drops lock.
      state_d = ST_HUNT;
      if (state_q == ST_LOCKED) begin
        lock_loss_d = sat_inc_cnt(lock_loss_q);
      end
    end else if (DATA_VALID) begin
      unique case (state_q)
        ST_HUNT: begin
          if (is_sync) begin
            state_d = ST_VERIFY;
            good_d  = 4'd1;
            pos_d   = POS_SSW;
          end
        end

        ST_VERIFY: begin
          pos_d = pos_nxt;
          if (pos_q == POS_SYNC) begin
            if (is_sync) begin
              good_d = sat_inc4(good_q);
            end else begin
              state_d = ST_HUNT;
            end
          end else if ((pos_q == POS_SSW) && (good_q >= LOCK_TH)) begin
            if (is_ssw) begin
              scr_d   = DATA_IN[57:0];
              bad_d   = 4'd0;
              mm_d    = 4'd0;
              state_d = ST_LOCKED;
            end else begin
              state_d = ST_HUNT;
            end
          end
        end

        ST_LOCKED: begin
          pos_d = pos_nxt;
          if (pos_q == POS_SYNC) begin
            if (is_sync) begin
              bad_d = 4'd0;
            end else begin
              sync_err_d = 1'b1;
              bad_d      = bad_inc;
              if (bad_inc >= LOSS_TH) begin
                state_d     = ST_HUNT;
                lock_loss_d = sat_inc_cnt(lock_loss_q);
              end
            end
          end else if (pos_q == POS_SSW) begin
            if (ssw_match) begin
              mm_d = 4'd0;
            end else begin
              // A real SSW with a different state resynchronises the
              // descrambler; a missing SSW leaves the state running.
              scr_err_d = 1'b1;
              scr_cnt_d = sat_inc_cnt(scr_cnt_q);
              mm_d      = mm_inc;
              if (is_ssw) begin
                scr_d = DATA_IN[57:0];
              end
              if (mm_inc >= MM_TH) begin
                state_d     = ST_HUNT;
                lock_loss_d = sat_inc_cnt(lock_loss_q);
              end
            end
          end else begin
            scr_d  = descr_s;
            dout_d = descr_data;
          end
        end

        default: begin
          state_d = ST_HUNT;
        end
      endcase
    end
  end

  // State and output registers; everything clears on the asynchronous reset.
  always_ff @(posedge USER_CLK or posedge SYSTEM_RESET) begin
    if (SYSTEM_RESET) begin
      state_q     <= ST_HUNT;
      pos_q       <= '0;
      good_q      <= '0;
      bad_q       <= '0;
      mm_q        <= '0;
      scr_q       <= '1;
      lock_loss_q <= '0;
      scr_cnt_q   <= '0;
      dout_q      <= '0;
      hdr_q       <= '0;
      dvo_q       <= 1'b0;
      sync_err_q  <= 1'b0;
      scr_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pos_q       <= pos_d;
      good_q      <= good_d;
      bad_q       <= bad_d;
      mm_q        <= mm_d;
      scr_q       <= scr_d;
      lock_loss_q <= lock_loss_d;
      scr_cnt_q   <= scr_cnt_d;
      dout_q      <= dout_d;
      hdr_q       <= hdr_d;
      dvo_q       <= dvo_d;
      sync_err_q  <= sync_err_d;
      scr_err_q   <= scr_err_d;
    end
  end

  assign DATA_OUT       = dout_q;
  assign HEADER_OUT     = hdr_q;
  assign DATA_VALID_OUT = dvo_q;
  assign LOCKED         = (state_q == ST_LOCKED);
  assign SYNC_ERR       = sync_err_q;
  assign SCR_STATE_ERR  = scr_err_q;
  assign LOCK_LOSS_CNT  = lock_loss_q;
  assign SCR_ERR_CNT    = scr_cnt_q;

endmodule

// File: tb/tb_interlaken_lane_descrambler.sv
// Bench for interlaken_lane_descrambler: a transmit-side scrambler produces
// the lane stream from random plaintext, and each received word is checked
// against the plaintext (locked payload) or the raw word (everything else).
module tb_interlaken_lane_descrambler;

  localparam int          LEN      = 16;
  localparam logic [63:0] SYNC     = 64'h78f678f678f678f6;
  // Flipping the newest state bit corrupts exactly the two bits whose taps
  // (s[38], s[57]) it passes through during the next 64-bit word.
  localparam logic [63:0] FLIP_ERR = (64'd1 << 57) | (64'd1 << 38);

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        dv  = 1'b0;
  logic        pt  = 1'b0;
  logic [1:0]  hdr = 2'b00;
  logic [63:0] din = 64'd0;
  logic [63:0] DATA_OUT;
  logic [1:0]  HEADER_OUT;
  logic        DATA_VALID_OUT, LOCKED, SYNC_ERR, SCR_STATE_ERR;
  logic [15:0] LOCK_LOSS_CNT, SCR_ERR_CNT;

  logic        dv2  = 1'b0;
  logic        pt2  = 1'b0;
  logic [1:0]  hdr2 = 2'b00;
  logic [63:0] din2 = 64'd0;
  logic [63:0] DATA_OUT2;
  logic [1:0]  HEADER_OUT2;
  logic        DATA_VALID_OUT2, LOCKED2, SYNC_ERR2, SCR_STATE_ERR2;
  logic [3:0]  LOCK_LOSS_CNT2, SCR_ERR_CNT2;

  int          n_chk = 0;
  int          n_fail = 0;
  logic [57:0] enc_s;
  bit          cur_lk = 1'b0;
  int          n_mm2 = 0;
  int          loss2 = 0;

  always #5 clk = ~clk;

  interlaken_lane_descrambler #(
    .META_FRAME_LEN(LEN), .SYNC_WORD(SYNC), .SYNC_LOCK_CNT(4),
    .SYNC_LOSS_CNT(4), .SCR_MISMATCH_CNT(3), .CNT_WIDTH(16)
  ) dut (
    .USER_CLK(clk), .SYSTEM_RESET(rst), .DATA_VALID(dv), .PASSTHROUGH(pt),
    .HEADER_IN(hdr), .DATA_IN(din), .DATA_OUT(DATA_OUT), .HEADER_OUT(HEADER_OUT),
    .DATA_VALID_OUT(DATA_VALID_OUT), .LOCKED(LOCKED), .SYNC_ERR(SYNC_ERR),
    .SCR_STATE_ERR(SCR_STATE_ERR), .LOCK_LOSS_CNT(LOCK_LOSS_CNT), .SCR_ERR_CNT(SCR_ERR_CNT)
  );

  interlaken_lane_descrambler #(
    .META_FRAME_LEN(4), .SYNC_WORD(SYNC), .SYNC_LOCK_CNT(1),
    .SYNC_LOSS_CNT(4), .SCR_MISMATCH_CNT(15), .CNT_WIDTH(4)
  ) dut2 (
    .USER_CLK(clk), .SYSTEM_RESET(rst), .DATA_VALID(dv2), .PASSTHROUGH(pt2),
    .HEADER_IN(hdr2), .DATA_IN(din2), .DATA_OUT(DATA_OUT2), .HEADER_OUT(HEADER_OUT2),
    .DATA_VALID_OUT(DATA_VALID_OUT2), .LOCKED(LOCKED2), .SYNC_ERR(SYNC_ERR2),
    .SCR_STATE_ERR(SCR_STATE_ERR2), .LOCK_LOSS_CNT(LOCK_LOSS_CNT2), .SCR_ERR_CNT(SCR_ERR_CNT2)
  );

  // Transmit scrambler: scrambled bit feeds back into the state.
  function automatic logic [121:0] scramble(input logic [63:0] p, input logic [57:0] s_in);
    logic [57:0] s;
    logic [63:0] c;
    s = s_in;
    c = '0;
    for (int i = 0; i < 64; i++) begin
      c[i] = p[i] ^ s[38] ^ s[57];
      s    = {s[56:0], c[i]};
    end
    return {s, c};
  endfunction

  task automatic chk(input logic [63:0] obs, input logic [63:0] exp, input string tag);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit v, input bit p, input logic [1:0] h, input logic [63:0] d,
                      input logic [63:0] exp_d, input bit el, input bit es, input bit ec,
                      input string tag);
    dv = v; pt = p; hdr = h; din = d;
    @(posedge clk); #1;
    chk(DATA_OUT, exp_d, {tag, ".data"});
    chk(64'(HEADER_OUT), 64'(h), {tag, ".hdr"});
    chk(64'(DATA_VALID_OUT), 64'(v), {tag, ".dvo"});
    chk(64'(LOCKED), 64'(el), {tag, ".locked"});
    chk(64'(SYNC_ERR), 64'(es), {tag, ".sync_err"});
    chk(64'(SCR_STATE_ERR), 64'(ec), {tag, ".scr_err"});
  endtask

  task automatic maybe_gap(input bit en);
    int          g;
    logic [63:0] r;
    if (en && ($urandom_range(0, 2) == 0)) begin
      g = $urandom_range(1, 5);
      for (int j = 0; j < g; j++) begin
        r = {$urandom, $urandom};
        step(1'b0, 1'b0, 2'b11, r, r, cur_lk, 1'b0, 1'b0, "gap");
      end
    end
  endtask

  task automatic send_frame(input bit sync_bad, input bit ssw_flip, input bit l0, input bit l1,
                            input bit serr, input bit scerr, input bit gaps, input int pt_idx);
    logic [63:0]  w, p, e;
    logic [121:0] r;
    maybe_gap(gaps);
    w = SYNC;
    if (sync_bad) w = SYNC ^ (64'd1 << $urandom_range(0, 63));
    step(1'b1, 1'b0, 2'b10, w, w, l0, serr, 1'b0, "sync");
    cur_lk = l0;
    maybe_gap(gaps);
    w = {6'b001010, enc_s ^ {57'd0, ssw_flip}};
    step(1'b1, 1'b0, 2'b10, w, w, l1, 1'b0, scerr, "ssw");
    cur_lk = l1;
    for (int k = 2; k < LEN; k++) begin
      maybe_gap(gaps);
      p     = {$urandom, $urandom};
      r     = scramble(p, enc_s);
      enc_s = r[121:64];
      w     = r[63:0];
      if (k == pt_idx) begin
        step(1'b1, 1'b1, 2'b01, w, w, 1'b0, 1'b0, 1'b0, "passthrough");
        cur_lk = 1'b0;
      end else begin
        e = cur_lk ? (p ^ ((k == 2 && ssw_flip) ? FLIP_ERR : 64'd0)) : w;
        step(1'b1, 1'b0, 2'b01, w, e, cur_lk, 1'b0, 1'b0, "payload");
      end
    end
  endtask

  task automatic step2(input logic [1:0] h, input logic [63:0] d, input bit el, input bit ec,
                       input string tag);
    dv2 = 1'b1; hdr2 = h; din2 = d;
    @(posedge clk); #1;
    chk(64'(LOCKED2), 64'(el), {tag, ".locked"});
    chk(64'(SCR_STATE_ERR2), 64'(ec), {tag, ".scr_err"});
    chk(64'(SCR_ERR_CNT2), 64'((n_mm2 > 15) ? 15 : n_mm2), {tag, ".scr_cnt"});
    chk(64'(LOCK_LOSS_CNT2), 64'(loss2), {tag, ".loss_cnt"});
  endtask

  task automatic frame2(input bit load_ssw, input bit lk_before, input bit lk_after);
    logic [63:0] w;
    bit          ec;
    step2(2'b10, SYNC, lk_before, 1'b0, "s2.sync");
    if (load_ssw) begin
      w  = {6'b001010, 58'({$urandom, $urandom})};
      ec = 1'b0;
    end else begin
      w  = {6'b000000, 58'({$urandom, $urandom})};
      ec = 1'b1;
      n_mm2++;
      if (n_mm2 == 15) loss2 = 1;
    end
    step2(2'b10, w, lk_after, ec, "s2.ssw");
    repeat (2) step2(2'b01, {$urandom, $urandom}, lk_after, 1'b0, "s2.payload");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected end of stimulus");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0]  p, w;
    logic [121:0] r;
    enc_s = 58'({$urandom, $urandom});

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk(DATA_OUT, 64'd0, "rst.data");
    chk(64'(HEADER_OUT), 64'd0, "rst.hdr");
    chk(64'(DATA_VALID_OUT), 64'd0, "rst.dvo");
    chk(64'(LOCKED), 64'd0, "rst.locked");
    chk(64'(SYNC_ERR), 64'd0, "rst.sync_err");
    chk(64'(SCR_STATE_ERR), 64'd0, "rst.scr_err");
    chk(64'(LOCK_LOSS_CNT), 64'd0, "rst.loss_cnt");
    chk(64'(SCR_ERR_CNT), 64'd0, "rst.scr_cnt");
    rst = 1'b0;

    // Acquisition: lock after the 4th metaframe's SSW
    repeat (3) send_frame(0, 0, 0, 0, 0, 0, 0, -1);
    send_frame(0, 0, 0, 1, 0, 0, 0, -1);
    send_frame(0, 0, 1, 1, 0, 0, 0, -1);
    chk(64'(LOCK_LOSS_CNT), 64'd0, "acq.loss_cnt");

    // Three bad syncs keep lock, four lose it
    repeat (3) send_frame(1, 0, 1, 1, 1, 0, 0, -1);
    send_frame(0, 0, 1, 1, 0, 0, 0, -1);
    repeat (3) send_frame(1, 0, 1, 1, 1, 0, 0, -1);
    send_frame(1, 0, 0, 0, 1, 0, 0, -1);
    chk(64'(LOCK_LOSS_CNT), 64'd1, "syncloss.loss_cnt");

    // Relock, then scrambler-state mismatches
    repeat (3) send_frame(0, 0, 0, 0, 0, 0, 0, -1);
    send_frame(0, 0, 0, 1, 0, 0, 0, -1);
    send_frame(0, 1, 1, 1, 0, 1, 0, -1);
    chk(64'(SCR_ERR_CNT), 64'd1, "mm1.scr_cnt");
    chk(64'(LOCK_LOSS_CNT), 64'd1, "mm1.loss_cnt");
    send_frame(0, 0, 1, 1, 0, 0, 0, -1);
    repeat (2) send_frame(0, 1, 1, 1, 0, 1, 0, -1);
    send_frame(0, 1, 1, 0, 0, 1, 0, -1);
    chk(64'(SCR_ERR_CNT), 64'd4, "mm3.scr_cnt");
    chk(64'(LOCK_LOSS_CNT), 64'd2, "mm3.loss_cnt");

    // Relock, then ten locked metaframes with random valid gaps
    repeat (3) send_frame(0, 0, 0, 0, 0, 0, 0, -1);
    send_frame(0, 0, 0, 1, 0, 0, 0, -1);
    repeat (10) send_frame(0, 0, 1, 1, 0, 0, 1, -1);
    chk(64'(LOCK_LOSS_CNT), 64'd2, "gaps.loss_cnt");
    chk(64'(SCR_ERR_CNT), 64'd4, "gaps.scr_cnt");

    // One-cycle passthrough mid-lock
    send_frame(0, 0, 1, 1, 0, 0, 0, 7);
    chk(64'(LOCK_LOSS_CNT), 64'd3, "pt.loss_cnt");
    repeat (3) begin
      p     = {$urandom, $urandom};
      r     = scramble(p, enc_s);
      enc_s = r[121:64];
      w     = r[63:0];
      step(1'b1, 1'b0, 2'b01, w, w, 1'b0, 1'b0, 1'b0, "hunt");
    end

    // Asynchronous reset between clock edges
    #2 rst = 1'b1;
    #1;
    chk(DATA_OUT, 64'd0, "arst.data");
    chk(64'(HEADER_OUT), 64'd0, "arst.hdr");
    chk(64'(DATA_VALID_OUT), 64'd0, "arst.dvo");
    chk(64'(LOCKED), 64'd0, "arst.locked");
    chk(64'(LOCK_LOSS_CNT), 64'd0, "arst.loss_cnt");
    chk(64'(SCR_ERR_CNT), 64'd0, "arst.scr_cnt");
    dv = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;

    // Counter saturation on the 4-bit instance: 18 mismatches with a resync
    frame2(1, 0, 1);
    for (int i = 1; i <= 15; i++) frame2(0, 1, (i < 15));
    frame2(1, 0, 1);
    repeat (3) frame2(0, 1, 1);
    chk(64'(SCR_ERR_CNT2), 64'hF, "sat.scr_cnt");
    dv2 = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/interlaken_lane_descrambler.md
Name: interlaken_lane_descrambler

Overview:
- Next-generation Interlaken 64b/67b receive-lane descrambler. Sits between the gearbox/block-sync output and the lane deskew/decoder.
- Acquires metaframe lock with parametrised good/bad sync thresholds and descrambles payload with the x^58+x^39+1 self-synchronising polynomial.
- Unlike its predecessor it tolerates DATA_VALID gaps without losing lock, validates control headers and block types, and exposes error pulses and saturating statistics counters.

Parameters:
- META_FRAME_LEN, 2048, metaframe length in words including sync and scrambler-state words; legal range 4..8192.
- SYNC_WORD, 64'h78f678f678f678f6, expected sync word value.
- SYNC_LOCK_CNT, 4, consecutive correctly placed sync words required before lock; legal range 1..15.
- SYNC_LOSS_CNT, 4, consecutive bad sync words while locked that cause loss of lock; legal range 1..15.
- SCR_MISMATCH_CNT, 3, consecutive scrambler-state mismatches while locked that cause loss of lock; legal range 1..15.
- CNT_WIDTH, 16, width of the statistics counters.

Ports:
- USER_CLK  in  1  lane clock; all logic on its rising edge.
- SYSTEM_RESET  in  1  reset, asynchronous, active-high.
- DATA_VALID  in  1  DATA_IN/HEADER_IN are valid this cycle.
- PASSTHROUGH  in  1  bypass: force HUNT, output raw data.
- HEADER_IN  in  2  67b framing header (2'b10 = control, 2'b01 = data).
- DATA_IN  in  64  scrambled word; bit 0 is processed first.
- DATA_OUT  out  64  descrambled word.
- HEADER_OUT  out  2  HEADER_IN delayed 1 cycle.
- DATA_VALID_OUT  out  1  DATA_VALID delayed 1 cycle.
- LOCKED  out  1  high in LOCKED state.
- SYNC_ERR  out  1  1-cycle pulse: bad sync word while locked.
- SCR_STATE_ERR  out  1  1-cycle pulse: scrambler-state mismatch while locked.
- LOCK_LOSS_CNT  out  CNT_WIDTH  number of LOCKED->HUNT transitions; saturates at all-ones.
- SCR_ERR_CNT  out  CNT_WIDTH  number of scrambler-state mismatches; saturates.

Behaviour:
- Reset (asynchronous): all outputs 0, state HUNT, descrambler state all-ones, all counters 0.
- Word classification:
  - Sync word: HEADER_IN==2'b10 and DATA_IN==SYNC_WORD.
  - Scrambler-state word (SSW): HEADER_IN==2'b10 and DATA_IN[63:58]==6'b001010; the state is carried in DATA_IN[57:0].
- Metaframe position pos runs 0..META_FRAME_LEN-1: pos 0 is sync, pos 1 is SSW, pos >=2 is payload. pos wraps to 0 after META_FRAME_LEN-1.
- DATA_VALID low: state, pos, descrambler state and all counters hold. Outputs still register, with DATA_VALID_OUT=0. A valid gap never drops lock.
- PASSTHROUGH high (on a valid or invalid cycle): state forced to HUNT and DATA_OUT=DATA_IN. LOCK_LOSS_CNT increments if the block was LOCKED.
- Descrambling:
  - For i=0..63: out[i]=in[i]^s[38]^s[57]; then s={s[56:0],in[i]}.
  - Applied only to valid payload words in LOCKED; s advances only on those words.
- Latency: 1 cycle for all outputs. DATA_OUT is the raw word for sync/SSW words and for any word outside LOCKED.
- State machine (evaluated only on valid cycles):
  - HUNT: on a sync word go to VERIFY with good=1, pos=1.
  - VERIFY:
    - At pos 0: a sync word increments good; a non-sync word returns to HUNT.
    - At pos 1 with good>=SYNC_LOCK_CNT: an SSW loads s=DATA_IN[57:0], clears the bad and mm counters and goes to LOCKED; a non-SSW returns to HUNT.
    - At pos 1 with good<SYNC_LOCK_CNT: the word is ignored.
  - LOCKED:
    - pos 0, non-sync word: SYNC_ERR=1, bad++. If bad reaches SYNC_LOSS_CNT, go to HUNT and increment LOCK_LOSS_CNT.
    - pos 0, sync word: bad=0.
    - pos 1, SSW with DATA_IN[57:0]==s: mm=0.
    - pos 1, SSW with DATA_IN[57:0]!=s: SCR_STATE_ERR=1, SCR_ERR_CNT++, s reloaded from the word, mm++.
    - pos 1, non-SSW: same as a mismatch, but s is not reloaded.
    - In either mismatch case, if mm reaches SCR_MISMATCH_CNT, go to HUNT and increment LOCK_LOSS_CNT.
- Simultaneous events: SYNC_LOSS and SCR_MISMATCH cannot coincide (different positions). PASSTHROUGH takes priority over every transition.

Test Plan:
- Reset then 5 clean metaframes (META_FRAME_LEN=16, SYNC_LOCK_CNT=4) -> LOCKED rises 1 cycle after the 4th metaframe's SSW. Payload from a reference scrambler seeded with the SSW state descrambles to the original pattern with 1-cycle latency.
- While locked, corrupt 3 consecutive sync words -> SYNC_ERR pulses 3 times and LOCKED stays high; corrupt 4 consecutive -> LOCKED drops after the 4th and LOCK_LOSS_CNT=1.
- While locked, one SSW with state bit 0 flipped -> SCR_STATE_ERR pulses once, SCR_ERR_CNT=1, LOCKED stays high, the next payload is descrambled with the reloaded state; 3 consecutive bad SSWs -> HUNT.
- Insert random DATA_VALID=0 gaps (1-5 cycles) across 10 locked metaframes -> no errors, LOCKED stays high, DATA_VALID_OUT mirrors the input, payload is correct.
- Assert PASSTHROUGH mid-lock for 1 cycle -> next cycle LOCKED=0, DATA_OUT=DATA_IN, LOCK_LOSS_CNT increments; assert SYSTEM_RESET asynchronously mid-frame -> all outputs 0 immediately.
- Force 2^CNT_WIDTH+2 SSW mismatches (SCR_MISMATCH_CNT=15, periodic resync) -> SCR_ERR_CNT saturates at all-ones.
